// File: rtl/fifo_rd_stream.sv
// Reader-side controller for a synchronous FIFO.
// Issues read strobes while a buffer slot is guaranteed, captures read data one
// cycle later and re-presents it as a valid/ready stream via a 2-entry skid buffer.
module fifo_rd_stream #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,      // active-high synchronous reset
    output logic              o_rden,
    input  logic              i_empty,
    input  logic [DATA_W-1:0] i_rddata,
    input  logic              i_flush,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_count
);

    logic [1:0]        occ_q, occ_d;
    logic              inflt_q, inflt_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              pop;
    logic [2:0]        pend;

    assign o_valid = (occ_q != 2'd0) & ~i_flush;
    assign pop     = o_valid & i_ready;
    // Slots that will be occupied after this edge if no further read is issued.
    assign pend    = {1'b0, occ_q} + {2'b00, inflt_q} - {2'b00, pop};
    assign o_rden  = ~rstn & ~i_flush & ~i_empty & (pend < 3'd2);
    assign o_data  = head_q;
    assign o_busy  = (occ_q != 2'd0) | inflt_q;
    assign o_count = count_q;

    // Next-state: capture in-flight word at the tail, retire the head on pop.
    always_comb begin
        occ_d   = occ_q;
        inflt_d = inflt_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (i_flush) begin
            occ_d   = 2'd0;
            inflt_d = 1'b0;
        end else begin
            inflt_d = o_rden;
            count_d = count_q + CNT_W'(pop);
            case ({inflt_q, pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        head_d = i_rddata;
                    end else begin
                        tail_d = i_rddata;
                    end
                    occ_d = occ_q + 2'd1;
                end
                2'b01: begin
                    head_d = tail_q;
                    occ_d  = occ_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; new word lands behind whatever remains.
                    if (occ_q == 2'd1) begin
                        head_d = i_rddata;
                    end else begin
                        head_d = tail_q;
                        tail_d = i_rddata;
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rstn) begin
            occ_q   <= 2'd0;
            inflt_q <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            occ_q   <= occ_d;
            inflt_q <= inflt_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: a queue-based FIFO and stream model
// predicts every output each cycle; directed phases plus a random phase.
module tb_fifo_rd_stream;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rstn;
    logic              o_rden;
    logic              i_empty;
    logic [DATA_W-1:0] i_rddata;
    logic              i_flush;
    logic              o_valid;
    logic              i_ready;
    logic [DATA_W-1:0] o_data;
    logic              o_busy;
    logic [CNT_W-1:0]  o_count;

    fifo_rd_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .o_rden   (o_rden),
        .i_empty  (i_empty),
        .i_rddata (i_rddata),
        .i_flush  (i_flush),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_data   (o_data),
        .o_busy   (o_busy),
        .o_count  (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    // Reference state: upstream FIFO contents, words buffered, word in flight.
    logic [DATA_W-1:0] fifo_q[$];
    logic [DATA_W-1:0] bq[$];
    logic [DATA_W-1:0] rd_word;
    bit                inflt;
    int                cnt;
    int                rden_run;
    int                valid_run;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs in the low phase, check, then advance the model.
    task automatic step(input bit rst, input bit flush, input bit ready);
        bit exp_valid, exp_pop, exp_rden, dut_rden;
        rstn     = rst;
        i_flush  = flush;
        i_ready  = ready;
        i_empty  = (fifo_q.size() == 0);
        i_rddata = inflt ? rd_word : DATA_W'($urandom);
        #1;
        exp_valid = (bq.size() != 0) && !flush;
        exp_pop   = exp_valid && ready;
        exp_rden  = !rst && !flush && (fifo_q.size() != 0) &&
                    ((bq.size() + int'(inflt) - int'(exp_pop)) < 2);
        chk("rden",  32'(o_rden),  32'(exp_rden));
        chk("valid", 32'(o_valid), 32'(exp_valid));
        chk("busy",  32'(o_busy),  32'((bq.size() != 0) || inflt));
        chk("count", 32'(o_count), 32'(cnt));
        if (exp_valid) chk("data", 32'(o_data), 32'(bq[0]));
        rden_run  = o_rden  ? rden_run + 1  : 0;
        valid_run = o_valid ? valid_run + 1 : 0;
        dut_rden  = o_rden;
        @(posedge clk);
        if (rst) begin
            bq.delete();
            inflt = 0;
            cnt   = 0;
        end else if (flush) begin
            bq.delete();
            inflt = 0;
        end else begin
            if (inflt) bq.push_back(rd_word);
            if (exp_pop) begin
                void'(bq.pop_front());
                cnt = (cnt + 1) % (1 << CNT_W);
            end
            inflt = exp_rden;
        end
        // The FIFO itself reacts to whatever strobe the DUT actually issued.
        if (dut_rden && fifo_q.size() != 0) rd_word = fifo_q.pop_front();
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit ready);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, ready);
    endtask

    task automatic load_rand(input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(DATA_W'($urandom));
    endtask

    initial begin
        rstn = 1'b1; i_flush = 1'b0; i_ready = 1'b0; i_empty = 1'b1; i_rddata = '0;
        inflt = 0; cnt = 0; rd_word = '0; rden_run = 0; valid_run = 0;
        @(negedge clk);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        rstn = 1'b0;
        #1;
        chk("reset_data",  32'(o_data),  32'h0);
        chk("reset_count", 32'(o_count), 32'h0);

        // Basic order.
        fifo_q.push_back(8'hA1); fifo_q.push_back(8'hB2); fifo_q.push_back(8'hC3);
        run(7, 1'b1);
        chk("basic_count", 32'(o_count), 32'd3);
        chk("basic_idle",  32'(o_busy),  32'd0);

        // Back-pressure: only two strobes may go out while the consumer stalls.
        load_rand(5);
        run(6, 1'b0);
        chk("bp_fifo_left", 32'(fifo_q.size()), 32'd3);
        run(10, 1'b1);
        chk("bp_count", 32'(o_count), 32'd8);

        // Streaming 16 words back to back.
        for (int i = 0; i < 16; i++) fifo_q.push_back(DATA_W'(i));
        begin
            int max_rden, max_valid;
            max_rden = 0; max_valid = 0;
            for (int i = 0; i < 20; i++) begin
                step(1'b0, 1'b0, 1'b1);
                if (rden_run > max_rden) max_rden = rden_run;
                if (valid_run > max_valid) max_valid = valid_run;
            end
            chk("stream_rden_run",  32'(max_rden),  32'd16);
            chk("stream_valid_run", 32'(max_valid), 32'd16);
        end

        // Flush with a full buffer.
        load_rand(5);
        run(3, 1'b0);
        begin
            int c0;
            c0 = cnt;
            step(1'b0, 1'b1, 1'b1);
            run(8, 1'b1);
            chk("flush_count", 32'(o_count), 32'((c0 + 3) % 16));
        end

        // Reset mid-operation.
        load_rand(6);
        run(4, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        rstn = 1'b0;
        #1;
        chk("midrst_data", 32'(o_data), 32'h0);
        run(10, 1'b1);

        // Randomised traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) load_rand($urandom_range(1, 3));
            step($urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 2) != 0);
        end
        run(10, 1'b1);

        // Counter wrap over 17 handshakes.
        step(1'b1, 1'b0, 1'b0);
        fifo_q.delete();
        for (int i = 0; i < 17; i++) fifo_q.push_back(DATA_W'(i));
        while (cnt < 15 && nchk < 20000) step(1'b0, 1'b0, 1'b1);
        chk("wrap_15", 32'(o_count), 32'd15);
        step(1'b0, 1'b0, 1'b1);
        chk("wrap_0", 32'(o_count), 32'd0);
        step(1'b0, 1'b0, 1'b1);
        chk("wrap_1", 32'(o_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
